// File: rtl/cache_data_bank_array_if.sv
// Bus bundle for cache_data_bank_array: line read, byte-masked store, refill handshake and parity flag.
// master = cache controller side, slave = data array side.
interface cache_data_bank_array_if #(
    parameter int NUM_BANKS  = 4,
    parameter int WORD_WIDTH = 32,
    parameter int INDEX_AW   = 8
);
    localparam int BE_W    = WORD_WIDTH / 8;
    localparam int BANK_AW = $clog2(NUM_BANKS);

    logic                            rd_en_i;
    logic [INDEX_AW-1:0]             rd_index_i;
    logic [NUM_BANKS*WORD_WIDTH-1:0] rd_data_o;
    logic                            rd_valid_o;

    logic                            wr_en_i;
    logic [INDEX_AW-1:0]             wr_index_i;
    logic [BANK_AW-1:0]              wr_bank_i;
    logic [BE_W-1:0]                 wr_be_i;
    logic [WORD_WIDTH-1:0]           wr_data_i;

    logic                            refill_start_i;
    logic [INDEX_AW-1:0]             refill_index_i;
    logic                            refill_valid_i;
    logic [WORD_WIDTH-1:0]           refill_data_i;
    logic                            refill_ready_o;
    logic                            refill_done_o;
    logic                            busy_o;

    logic                            err_inject_i;
    logic                            parity_err_o;

    modport master (
        output rd_en_i, rd_index_i,
        input  rd_data_o, rd_valid_o,
        output wr_en_i, wr_index_i, wr_bank_i, wr_be_i, wr_data_i,
        output refill_start_i, refill_index_i, refill_valid_i, refill_data_i,
        input  refill_ready_o, refill_done_o, busy_o,
        output err_inject_i,
        input  parity_err_o
    );

    modport slave (
        input  rd_en_i, rd_index_i,
        output rd_data_o, rd_valid_o,
        input  wr_en_i, wr_index_i, wr_bank_i, wr_be_i, wr_data_i,
        input  refill_start_i, refill_index_i, refill_valid_i, refill_data_i,
        output refill_ready_o, refill_done_o, busy_o,
        input  err_inject_i,
        output parity_err_o
    );
endinterface

// File: rtl/cache_data_bank_array.sv
// Banked cache data array with full-line read, byte-masked store and a one-word-per-beat refill FSM.
// Optional per-byte even parity is enabled by defining CACHE_BANK_PARITY_EN.
module cache_data_bank_array #(
    parameter int NUM_BANKS  = 4,
    parameter int WORD_WIDTH = 32,
    parameter int INDEX_AW   = 8
) (
    input logic                  clk,
    input logic                  rst,
    cache_data_bank_array_if.slave bus
);
    localparam int BE_W    = WORD_WIDTH / 8;
    localparam int BANK_AW = $clog2(NUM_BANKS);
    localparam int DEPTH   = 1 << INDEX_AW;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                          state, state_nxt;
    logic [BANK_AW-1:0]              beat_cnt, beat_cnt_nxt;
    logic [INDEX_AW-1:0]             fill_index, fill_index_nxt;
    logic                            rd_fire, wr_fire, beat_fire;
    logic [NUM_BANKS*WORD_WIDTH-1:0] rd_line;
    logic                            rd_mismatch;

    logic [WORD_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

    function automatic logic [BE_W-1:0] byte_parity(input logic [WORD_WIDTH-1:0] w);
        logic [BE_W-1:0] p;
        for (int i = 0; i < BE_W; i++) p[i] = ^w[i*8 +: 8];
        return p;
    endfunction

    // Requests are only honoured outside FILL; the requester holds them until busy drops.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        state_nxt          = state;
        beat_cnt_nxt       = beat_cnt;
        fill_index_nxt     = fill_index;
        rd_fire            = 1'b0;
        wr_fire            = 1'b0;
        beat_fire          = 1'b0;
        bus.refill_ready_o = 1'b0;
        bus.refill_done_o  = 1'b0;
        bus.busy_o         = 1'b0;
        case (state)
            IDLE: begin
                rd_fire = bus.rd_en_i;
                wr_fire = bus.wr_en_i;
                if (bus.refill_start_i) begin
                    state_nxt      = FILL;
                    fill_index_nxt = bus.refill_index_i;
                    beat_cnt_nxt   = '0;
                end
            end
            FILL: begin
                bus.refill_ready_o = 1'b1;
                bus.busy_o         = 1'b1;
                beat_fire          = bus.refill_valid_i;
                if (beat_fire) begin
                    if (beat_cnt == BANK_AW'(NUM_BANKS - 1)) begin
                        state_nxt    = DONE;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                bus.refill_done_o = 1'b1;
                rd_fire           = bus.rd_en_i;
                wr_fire           = bus.wr_en_i;
                state_nxt         = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the storage array has no reset; only control state and output registers are cleared.
    always_ff @(posedge clk) begin
        if (beat_fire) begin
            mem[beat_cnt][fill_index] <= bus.refill_data_i;
        end else if (wr_fire) begin
            for (int i = 0; i < BE_W; i++)
                if (bus.wr_be_i[i])
                    mem[bus.wr_bank_i][bus.wr_index_i][i*8 +: 8] <= bus.wr_data_i[i*8 +: 8];
        end
    end

`ifdef CACHE_BANK_PARITY_EN
    logic [BE_W-1:0] pmem [NUM_BANKS][DEPTH];

    always_ff @(posedge clk) begin
        if (beat_fire) begin
            pmem[beat_cnt][fill_index] <= byte_parity(bus.refill_data_i);
        end else if (wr_fire) begin
            for (int i = 0; i < BE_W; i++)
                if (bus.wr_be_i[i])
                    pmem[bus.wr_bank_i][bus.wr_index_i][i] <= (^bus.wr_data_i[i*8 +: 8]) ^ bus.err_inject_i;
        end
    end
`else
    logic unused_err_inject;
    assign unused_err_inject = bus.err_inject_i;
`endif

    // Write-first: a same-cycle store to the read index is merged into the line being read.
    always_comb begin
        logic [WORD_WIDTH-1:0] word;
        logic [BE_W-1:0]       par;
        logic                  hit;
        rd_line     = '0;
        rd_mismatch = 1'b0;
        word        = '0;
        par         = '0;
        hit         = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            word = mem[b][bus.rd_index_i];
`ifdef CACHE_BANK_PARITY_EN
            par = pmem[b][bus.rd_index_i];
`endif
            hit = wr_fire && (bus.wr_index_i == bus.rd_index_i) && (bus.wr_bank_i == BANK_AW'(b));
            for (int i = 0; i < BE_W; i++) begin
                if (hit && bus.wr_be_i[i]) begin
                    word[i*8 +: 8] = bus.wr_data_i[i*8 +: 8];
                    par[i]         = (^bus.wr_data_i[i*8 +: 8]) ^ bus.err_inject_i;
                end
            end
`ifdef CACHE_BANK_PARITY_EN
            rd_mismatch = rd_mismatch | (byte_parity(word) != par);
`endif
            rd_line[b*WORD_WIDTH +: WORD_WIDTH] = word;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            beat_cnt         <= '0;
            fill_index       <= '0;
            bus.rd_data_o    <= '0;
            bus.rd_valid_o   <= 1'b0;
            bus.parity_err_o <= 1'b0;
        end else begin
            state            <= state_nxt;
            beat_cnt         <= beat_cnt_nxt;
            fill_index       <= fill_index_nxt;
            bus.rd_valid_o   <= rd_fire;
            bus.parity_err_o <= rd_fire & rd_mismatch;
            if (rd_fire) bus.rd_data_o <= rd_line;
        end
    end
endmodule

// File: tb/tb_cache_data_bank_array.sv
// Randomized bench for cache_data_bank_array against a word-array reference model.
// Expected parity behaviour follows CACHE_BANK_PARITY_EN as compiled.
module tb_cache_data_bank_array;
    localparam int NB  = 4;
    localparam int WW  = 32;
    localparam int IAW = 8;
    localparam int BEW = WW / 8;
    localparam int LW  = NB * WW;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cache_data_bank_array_if #(.NUM_BANKS(NB), .WORD_WIDTH(WW), .INDEX_AW(IAW)) bus ();
    cache_data_bank_array #(.NUM_BANKS(NB), .WORD_WIDTH(WW), .INDEX_AW(IAW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: plain word array, per-byte "parity corrupted" flags and a last-read register.
    logic [WW-1:0]  mdl   [256][NB];
    logic [BEW-1:0] mbad  [256][NB];
    bit             known [256];
    logic [LW-1:0]  exp_rd = '0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_en_i        = 1'b0;
        bus.rd_index_i     = '0;
        bus.wr_en_i        = 1'b0;
        bus.wr_index_i     = '0;
        bus.wr_bank_i      = '0;
        bus.wr_be_i        = '0;
        bus.wr_data_i      = '0;
        bus.refill_start_i = 1'b0;
        bus.refill_index_i = '0;
        bus.refill_valid_i = 1'b0;
        bus.refill_data_i  = '0;
        bus.err_inject_i   = 1'b0;
    endtask

    function automatic logic [7:0] pick();
        return 8'(($urandom % 16) << 4);
    endfunction

    function automatic logic [LW-1:0] line_of(input int idx);
        logic [LW-1:0] l;
        for (int b = 0; b < NB; b++) l[b*WW +: WW] = mdl[idx][b];
        return l;
    endfunction

    function automatic logic perr_of(input int idx);
`ifdef CACHE_BANK_PARITY_EN
        for (int b = 0; b < NB; b++) if (mbad[idx][b] != '0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // One accepted-cycle operation: optional read and/or store, then check the registered read result.
    task automatic cycle_op(input bit rd, input logic [7:0] ridx, input bit wr, input logic [7:0] widx,
                            input logic [1:0] bank, input logic [BEW-1:0] be, input logic [WW-1:0] data,
                            input bit inj);
        logic exp_perr;
        bus.rd_en_i      = rd;
        bus.rd_index_i   = ridx;
        bus.wr_en_i      = wr;
        bus.wr_index_i   = widx;
        bus.wr_bank_i    = bank;
        bus.wr_be_i      = be;
        bus.wr_data_i    = data;
        bus.err_inject_i = inj;
        if (wr) begin
            for (int i = 0; i < BEW; i++) begin
                if (be[i]) begin
                    mdl[widx][bank][i*8 +: 8] = data[i*8 +: 8];
                    mbad[widx][bank][i]       = inj;
                end
            end
        end
        exp_perr = 1'b0;
        if (rd) begin
            exp_rd   = line_of(ridx);
            exp_perr = perr_of(ridx);
        end
        step();
        idle();
        check("rd_valid", LW'(bus.rd_valid_o), LW'(rd));
        if (!rd || known[ridx]) begin
            check("rd_data", bus.rd_data_o, exp_rd);
            check("parity_err", LW'(bus.parity_err_o), LW'(exp_perr));
        end
    endtask

    // Refill a line with randomly gapped beats while throwing ignored requests at the array.
    // With gap=1 the beats are A0..A3 and valid drops for two cycles after beat 1.
    // abort_after < NB asserts reset once that many beats have been accepted.
    task automatic do_refill(input logic [7:0] idx, input bit gap, input int abort_after);
        logic [WW-1:0] beats [NB];
        int n    = 0;
        int cyc  = 0;
        int gapc = 0;
        bit v;
        for (int b = 0; b < NB; b++) beats[b] = gap ? (WW'(32'hA000_0000) | WW'(b)) : WW'($urandom);
        bus.refill_start_i = 1'b1;
        bus.refill_index_i = idx;
        step();
        bus.refill_start_i = 1'b0;
        check("busy_after_start", LW'(bus.busy_o), LW'(1));
        while (n < NB && cyc < 100) begin
            if (n == abort_after) begin
                rst = 1'b1;
                #2;
                check("rst_rd_data", bus.rd_data_o, '0);
                check("rst_rd_valid", LW'(bus.rd_valid_o), '0);
                check("rst_ready", LW'(bus.refill_ready_o), '0);
                check("rst_done", LW'(bus.refill_done_o), '0);
                check("rst_busy", LW'(bus.busy_o), '0);
                check("rst_parity", LW'(bus.parity_err_o), '0);
                @(posedge clk);
                #1;
                rst        = 1'b0;
                idle();
                known[idx] = 1'b0;
                exp_rd     = '0;
                step();
                check("busy_after_rst", LW'(bus.busy_o), '0);
                return;
            end
            if (gap && n == 2 && gapc < 2) begin
                v = 1'b0;
                gapc++;
            end else begin
                v = ($urandom_range(0, 3) != 0);
            end
            bus.refill_valid_i = v;
            bus.refill_data_i  = v ? beats[n] : WW'($urandom);
            bus.rd_en_i        = $urandom_range(0, 1) != 0;
            bus.rd_index_i     = pick();
            bus.wr_en_i        = $urandom_range(0, 1) != 0;
            bus.wr_index_i     = pick();
            bus.wr_bank_i      = 2'($urandom);
            bus.wr_be_i        = BEW'($urandom);
            bus.wr_data_i      = WW'($urandom);
            bus.err_inject_i   = $urandom_range(0, 1) != 0;
            bus.refill_start_i = $urandom_range(0, 1) != 0;
            bus.refill_index_i = pick();
            check("fill_ready", LW'(bus.refill_ready_o), LW'(1));
            check("fill_busy", LW'(bus.busy_o), LW'(1));
            check("fill_done", LW'(bus.refill_done_o), '0);
            step();
            check("fill_rd_valid", LW'(bus.rd_valid_o), '0);
            check("fill_rd_data_hold", bus.rd_data_o, exp_rd);
            if (v) n++;
            cyc++;
        end
        idle();
        check("refill_beats", LW'(n), LW'(NB));
        if (n < NB) return;
        check("done_pulse", LW'(bus.refill_done_o), LW'(1));
        check("done_busy", LW'(bus.busy_o), '0);
        check("done_ready", LW'(bus.refill_ready_o), '0);
        for (int b = 0; b < NB; b++) begin
            mdl[idx][b]  = beats[b];
            mbad[idx][b] = '0;
        end
        known[idx] = 1'b1;
        cycle_op(1'b1, idx, 1'b0, '0, '0, '0, '0, 1'b0);
        check("done_single_pulse", LW'(bus.refill_done_o), '0);
    endtask

    initial begin
        logic [WW-1:0] w;
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_data", bus.rd_data_o, '0);
        check("reset_rd_valid", LW'(bus.rd_valid_o), '0);
        check("reset_ready", LW'(bus.refill_ready_o), '0);
        check("reset_done", LW'(bus.refill_done_o), '0);
        check("reset_busy", LW'(bus.busy_o), '0);
        check("reset_parity", LW'(bus.parity_err_o), '0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 16; i++) if (i != 1) do_refill(8'(i << 4), 1'b0, NB);
        do_refill(8'h10, 1'b1, NB);
        check("refill_0x10_line", line_of(8'h10),
              {WW'(32'hA000_0003), WW'(32'hA000_0002), WW'(32'hA000_0001), WW'(32'hA000_0000)});

        cycle_op(1'b0, '0, 1'b1, 8'h10, 2'd2, 4'b0011, 32'hDEADBEEF, 1'b0);
        cycle_op(1'b1, 8'h10, 1'b0, '0, '0, '0, '0, 1'b0);
        check("store_bank2", bus.rd_data_o[2*WW +: WW], {16'hA000, 16'hBEEF});

        cycle_op(1'b1, 8'h20, 1'b1, 8'h20, 2'd0, 4'hF, 32'h12345678, 1'b0);
        check("write_first_bank0", bus.rd_data_o[WW-1:0], 32'h12345678);

        do_refill(8'h30, 1'b0, 2);
        do_refill(8'h30, 1'b0, NB);

        w = WW'($urandom);
        cycle_op(1'b0, '0, 1'b1, 8'h40, 2'd1, 4'b0100, w, 1'b1);
        cycle_op(1'b1, 8'h40, 1'b0, '0, '0, '0, '0, 1'b0);
        cycle_op(1'b0, '0, 1'b1, 8'h40, 2'd1, 4'b0100, w, 1'b0);
        cycle_op(1'b1, 8'h40, 1'b0, '0, '0, '0, '0, 1'b0);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 24) == 0) begin
                do_refill(pick(), 1'b0, NB);
            end else begin
                cycle_op($urandom_range(0, 1) != 0, pick(), $urandom_range(0, 1) != 0, pick(),
                         2'($urandom), BEW'($urandom), WW'($urandom), $urandom_range(0, 7) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
